status_register: RTL and testbench
==================================

# status_register

Processor status (P) register stage directly downstream of the ALU. It captures the ALU result and carry and derives the N, Z, C and V flags, computing V locally because the ALU produces no overflow output. It also executes the flag-set/clear instructions, PLP/RTI loads and interrupt-entry I-setting. It provides the live P value, the stacked P value, the carry fed back to the ALU, and the branch-condition decision to the control unit.

## Interface
Parameters:
- RESET_P, 8'h24, P value after reset: I=1, bit5=1, all other flags 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when low, all state holds (rst still acts).
- alu_a  input  8  ALU operand a, same cycle as alu_y.
- alu_b  input  8  ALU operand b, or memory operand for BIT.
- alu_y  input  8  ALU result.
- alu_carry  input  1  ALU carry_out. For SUB this is already in 6502 sense: 1 = no borrow.
- alu_sub  input  1  1 = current ALU op is SUB; selects V formula.
- upd_nz  input  1  load N and Z from alu_y.
- upd_c  input  1  load C from alu_carry.
- upd_v  input  1  load V from the overflow computation.
- bit_mode  input  1  BIT instruction: N<=alu_b[7], V<=alu_b[6], Z<=(alu_y==0); overrides upd_nz/upd_v.
- flag_op  input  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED.
- p_load  input  1  load from p_in (PLP/RTI).
- p_in  input  8  stacked P value.
- irq_entry  input  1  interrupt/BRK entry; forces I=1.
- push_brk  input  1  B bit value inserted in p_push.
- br_sel  input  2  branch flag select: 0 N, 1 V, 2 C, 3 Z (opcode bits 7:6).
- br_val  input  1  required flag value (opcode bit 5).
- p  output  8  live P: {N,V,1,0,D,I,Z,C}.
- p_push  output  8  {N,V,1,push_brk,D,I,Z,C}; combinational.
- carry_to_alu  output  1  registered C, for the ALU carry_in.
- br_taken  output  1  (selected flag == br_val); combinational from registered flags.

## Operation
- State: six flip-flops: N, V, D, I, Z, C. Bits 5 and 4 of p are constants 1 and 0.
- Reset: p = RESET_P (8'h24); carry_to_alu = 0; br_taken follows the reset flag values.
- Cycle with en=1 and rst=0. Per-flag priority, highest first:
  1. p_load: N,V,D,I,Z,C <= p_in[7,6,3,2,1,0]. p_in[5:4] are ignored. All other sources are ignored, except rule 2.
  2. irq_entry: I <= 1. This also wins over p_load and CLI in the same cycle.
  3. flag_op: acts on its target flag only.
  4. ALU update:
     - N <= alu_y[7]; Z <= (alu_y == 8'h00).
     - C <= alu_carry.
     - V:
       - ADD: V = (alu_a[7] == alu_b[7]) & (alu_y[7] != alu_a[7]).
       - SUB: V = (alu_a[7] != alu_b[7]) & (alu_y[7] != alu_a[7]).
  5. Otherwise the flag holds.
- bit_mode with upd_c=0 leaves C untouched.
- Flags not addressed by the active controls hold their value.
- en=0: no flag changes even if controls are asserted. p_push and br_taken still reflect the held state.
- D is stored only. No decimal behaviour is implemented here.

## Timing
- Update latency: 1 cycle. Controls sampled at edge k are visible on p and carry_to_alu after edge k; the last flag-updating edge is called k.
- A branch evaluated in the cycle after edge k sees the new flags.
- No handshake. Every control is a single-cycle qualifier. Holding a control for N cycles reapplies it N times, which is idempotent for all controls.
- rst asserted mid-sequence: next edge gives RESET_P regardless of other inputs, including en=0.
- Simultaneous SEC and upd_c=1 with alu_carry=0: C=1.
- Simultaneous p_load and upd_nz: p_in wins.
- Simultaneous CLI and irq_entry: I=1.
- Zero test is on the full 8 bits. Sign and overflow use bit 7 only. No width extension.

## Test plan
- Reset: assert rst 1 cycle with p_load=1, p_in=8'hFF -> p=8'h24, p_push with push_brk=1 = 8'h34, carry_to_alu=0.
- ADD overflow: a=8'h50, b=8'h50, y=8'hA0, carry=0, upd_nz/c/v=1 -> p=8'hE4 (N=1,V=1,Z=0,C=0). Then a=8'hFF, b=8'h01, y=8'h00, carry=1 -> N=0, V=0, Z=1, C=1.
- SUB overflow: alu_sub=1, a=8'h80, b=8'h01, y=8'h7F, carry=1 -> V=1, N=0, C=1. Then a=8'h05, b=8'h03, y=8'h02 -> V=0.
- BIT plus priority: bit_mode=1, alu_b=8'hC0, alu_y=8'h00, upd_c=0 -> N=1, V=1, Z=1, C unchanged. Next, flag_op=SEC with upd_c=1, alu_carry=0 -> C=1.
- PLP/IRQ collision: p_load=1, p_in=8'h00, irq_entry=1 -> p=8'h24. With en=0, SED -> D stays 0. With en=1, SED -> p[3]=1.
- Branch: for each br_sel with flag 0/1 and br_val 0/1, br_taken=(flag==br_val). After SEC at edge k, BCS (br_sel=2, br_val=1) -> br_taken=1 in cycle k+1, and was 0 before edge k.

Source files
------------

// File: rtl/status_register_if.sv
// status_register_if: ALU-side, control-side and flag-output signals of the P register stage
//   master drives en, ALU operands/result/carry, update strobes, flag_op, p_load/p_in, irq_entry,
//   push_brk and branch select; slave returns p, p_push, carry_to_alu and br_taken.
interface status_register_if;
  logic       en;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_y;
  logic       alu_carry;
  logic       alu_sub;
  logic       upd_nz;
  logic       upd_c;
  logic       upd_v;
  logic       bit_mode;
  logic [2:0] flag_op;
  logic       p_load;
  logic [7:0] p_in;
  logic       irq_entry;
  logic       push_brk;
  logic [1:0] br_sel;
  logic       br_val;
  logic [7:0] p;
  logic [7:0] p_push;
  logic       carry_to_alu;
  logic       br_taken;
  modport master (
    output en, alu_a, alu_b, alu_y, alu_carry, alu_sub, upd_nz, upd_c, upd_v, bit_mode,
           flag_op, p_load, p_in, irq_entry, push_brk, br_sel, br_val,
    input  p, p_push, carry_to_alu, br_taken
  );
  modport slave (
    input  en, alu_a, alu_b, alu_y, alu_carry, alu_sub, upd_nz, upd_c, upd_v, bit_mode,
           flag_op, p_load, p_in, irq_entry, push_brk, br_sel, br_val,
    output p, p_push, carry_to_alu, br_taken
  );
endinterface

// File: rtl/status_register.sv
// status_register: 6502 P register fed by the ALU; derives N/Z/C/V, runs flag ops, PLP/RTI and IRQ entry
//   clk, rst: clock and synchronous active-high reset
//   bus (slave): ALU result/operands, update controls, stacked P in; p, p_push, carry_to_alu, br_taken out
module status_register #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input logic           clk,
  input logic           rst,
  status_register_if.slave bus
);
  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic ovf, y_zero;
  logic [3:0] br_f;
  // Overflow: result sign differs from a, with operand signs equal for ADD and different for SUB.
  assign ovf    = (bus.alu_y[7] ^ bus.alu_a[7]) & ((bus.alu_a[7] ^ bus.alu_b[7]) == bus.alu_sub);
  assign y_zero = bus.alu_y == 8'h00;
  always_comb begin
    n_d = bus.p_load ? bus.p_in[7] :
          bus.bit_mode ? bus.alu_b[7] :
          bus.upd_nz ? bus.alu_y[7] : n_q;
    v_d = bus.p_load ? bus.p_in[6] :
          bus.flag_op == 3'd5 ? 1'b0 :
          bus.bit_mode ? bus.alu_b[6] :
          bus.upd_v ? ovf : v_q;
    d_d = bus.p_load ? bus.p_in[3] :
          bus.flag_op == 3'd6 ? 1'b0 :
          bus.flag_op == 3'd7 ? 1'b1 : d_q;
    i_d = bus.irq_entry ? 1'b1 :
          bus.p_load ? bus.p_in[2] :
          bus.flag_op == 3'd3 ? 1'b0 :
          bus.flag_op == 3'd4 ? 1'b1 : i_q;
    z_d = bus.p_load ? bus.p_in[1] :
          (bus.bit_mode | bus.upd_nz) ? y_zero : z_q;
    c_d = bus.p_load ? bus.p_in[0] :
          bus.flag_op == 3'd1 ? 1'b0 :
          bus.flag_op == 3'd2 ? 1'b1 :
          bus.upd_c ? bus.alu_carry : c_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {n_q, v_q, d_q, i_q, z_q, c_q} <= {RESET_P[7:6], RESET_P[3:0]};
    end else if (bus.en) begin
      {n_q, v_q, d_q, i_q, z_q, c_q} <= {n_d, v_d, d_d, i_d, z_d, c_d};
    end
  end
  assign br_f             = {z_q, c_q, v_q, n_q};
  assign bus.p            = {n_q, v_q, 2'b10, d_q, i_q, z_q, c_q};
  assign bus.p_push       = {n_q, v_q, 1'b1, bus.push_brk, d_q, i_q, z_q, c_q};
  assign bus.carry_to_alu = c_q;
  assign bus.br_taken     = br_f[bus.br_sel] == bus.br_val;
endmodule

// File: tb/tb_status_register.sv
// tb_status_register: directed and randomized checks of status_register against a flag-rule model
module tb_status_register;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total    = 0;
  logic [7:0] m;
  status_register_if bus ();
  status_register #(.RESET_P(8'h24)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [7:0] model_next(input logic [7:0] cur);
    logic n, v, d, i, z, c;
    {n, v, d, i, z, c} = {cur[7:6], cur[3:0]};
    if (bus.upd_nz) begin n = bus.alu_y[7]; z = (bus.alu_y == 0); end
    if (bus.upd_c) c = bus.alu_carry;
    if (bus.upd_v)
      v = bus.alu_sub ? ((bus.alu_a[7] != bus.alu_b[7]) && (bus.alu_y[7] != bus.alu_a[7]))
                      : ((bus.alu_a[7] == bus.alu_b[7]) && (bus.alu_y[7] != bus.alu_a[7]));
    if (bus.bit_mode) begin n = bus.alu_b[7]; v = bus.alu_b[6]; z = (bus.alu_y == 0); end
    case (bus.flag_op)
      3'd1: c = 0;
      3'd2: c = 1;
      3'd3: i = 0;
      3'd4: i = 1;
      3'd5: v = 0;
      3'd6: d = 0;
      3'd7: d = 1;
      default: ;
    endcase
    if (bus.p_load) {n, v, d, i, z, c} = {bus.p_in[7:6], bus.p_in[3:0]};
    if (bus.irq_entry) i = 1;
    return {n, v, 2'b10, d, i, z, c};
  endfunction

  function automatic logic model_br(input logic [7:0] pv, input logic [1:0] s, input logic bv);
    logic f;
    f = (s == 0) ? pv[7] : (s == 1) ? pv[6] : (s == 2) ? pv[0] : pv[1];
    return f == bv;
  endfunction

  task automatic idle();
    rst = 0; bus.en = 1; bus.alu_a = 0; bus.alu_b = 0; bus.alu_y = 0; bus.alu_carry = 0;
    bus.alu_sub = 0; bus.upd_nz = 0; bus.upd_c = 0; bus.upd_v = 0; bus.bit_mode = 0;
    bus.flag_op = 0; bus.p_load = 0; bus.p_in = 0; bus.irq_entry = 0; bus.push_brk = 0;
    bus.br_sel = 0; bus.br_val = 0;
  endtask

  task automatic step();
    logic [7:0] nm;
    nm = rst ? 8'h24 : (bus.en ? model_next(m) : m);
    @(posedge clk);
    #1 m = nm;
  endtask

  task automatic alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] y,
                     input logic cy, input logic sub);
    idle();
    bus.alu_a = a; bus.alu_b = b; bus.alu_y = y; bus.alu_carry = cy; bus.alu_sub = sub;
    bus.upd_nz = 1; bus.upd_c = 1; bus.upd_v = 1;
    step();
  endtask

  task automatic test_reset();
    idle();
    rst = 1; bus.p_load = 1; bus.p_in = 8'hFF; bus.push_brk = 1;
    step();
    total++; if (bus.p !== 8'h24) $display("FAIL reset_p got %h want 24", bus.p); else pass_cnt++;
    total++; if (bus.p_push !== 8'h34) $display("FAIL reset_push got %h want 34", bus.p_push); else pass_cnt++;
    total++; if (bus.carry_to_alu !== 1'b0) $display("FAIL reset_carry got %b want 0", bus.carry_to_alu); else pass_cnt++;
  endtask

  task automatic test_add();
    alu(8'h50, 8'h50, 8'hA0, 0, 0);
    total++; if (bus.p !== 8'hE4) $display("FAIL add_ovf got %h want e4", bus.p); else pass_cnt++;
    alu(8'hFF, 8'h01, 8'h00, 1, 0);
    total++; if (bus.p !== 8'h27) $display("FAIL add_zero got %h want 27", bus.p); else pass_cnt++;
    total++; if (bus.carry_to_alu !== 1'b1) $display("FAIL add_carry got %b want 1", bus.carry_to_alu); else pass_cnt++;
  endtask

  task automatic test_sub();
    alu(8'h80, 8'h01, 8'h7F, 1, 1);
    total++; if (bus.p !== 8'h65) $display("FAIL sub_ovf got %h want 65", bus.p); else pass_cnt++;
    alu(8'h05, 8'h03, 8'h02, 1, 1);
    total++; if (bus.p !== 8'h25) $display("FAIL sub_novf got %h want 25", bus.p); else pass_cnt++;
  endtask

  task automatic test_bit();
    idle(); bus.bit_mode = 1; bus.alu_b = 8'hC0; bus.alu_y = 8'h00; bus.alu_carry = 0;
    step();
    total++; if (bus.p !== 8'hE7) $display("FAIL bit got %h want e7", bus.p); else pass_cnt++;
    idle(); bus.flag_op = 3'd1; step();
    total++; if (bus.p !== 8'hE6) $display("FAIL clc got %h want e6", bus.p); else pass_cnt++;
    idle(); bus.flag_op = 3'd2; bus.upd_c = 1; bus.alu_carry = 0; step();
    total++; if (bus.p !== 8'hE7) $display("FAIL sec_vs_alu got %h want e7", bus.p); else pass_cnt++;
    idle(); bus.p_load = 1; bus.p_in = 8'h81; bus.upd_nz = 1; bus.alu_y = 8'h00; step();
    total++; if (bus.p !== 8'hA1) $display("FAIL plp_vs_nz got %h want a1", bus.p); else pass_cnt++;
  endtask

  task automatic test_plp_irq();
    idle(); bus.p_load = 1; bus.p_in = 8'h00; bus.irq_entry = 1; step();
    total++; if (bus.p !== 8'h24) $display("FAIL plp_irq got %h want 24", bus.p); else pass_cnt++;
    idle(); bus.flag_op = 3'd3; bus.irq_entry = 1; step();
    total++; if (bus.p !== 8'h24) $display("FAIL cli_irq got %h want 24", bus.p); else pass_cnt++;
    idle(); bus.en = 0; bus.flag_op = 3'd7; step();
    total++; if (bus.p !== 8'h24) $display("FAIL sed_en0 got %h want 24", bus.p); else pass_cnt++;
    idle(); bus.flag_op = 3'd7; step();
    total++; if (bus.p !== 8'h2C) $display("FAIL sed got %h want 2c", bus.p); else pass_cnt++;
    idle(); bus.en = 0; rst = 1; step();
    total++; if (bus.p !== 8'h24) $display("FAIL rst_en0 got %h want 24", bus.p); else pass_cnt++;
  endtask

  task automatic test_branch();
    logic [7:0] mask [4] = '{8'h80, 8'h40, 8'h01, 8'h02};
    for (int s = 0; s < 4; s++)
      for (int f = 0; f < 2; f++) begin
        idle(); bus.p_load = 1; bus.p_in = f[0] ? mask[s] : 8'h00; step();
        for (int b = 0; b < 2; b++) begin
          bus.br_sel = s[1:0]; bus.br_val = b[0]; #1;
          total++;
          if (bus.br_taken !== (f == b))
            $display("FAIL br sel=%0d f=%0d v=%0d got %b want %b", s, f, b, bus.br_taken, f == b);
          else pass_cnt++;
        end
      end
    idle(); bus.flag_op = 3'd1; step();
    bus.br_sel = 2; bus.br_val = 1; bus.flag_op = 3'd2; #1;
    total++; if (bus.br_taken !== 1'b0) $display("FAIL bcs_before got %b want 0", bus.br_taken); else pass_cnt++;
    step();
    total++; if (bus.br_taken !== 1'b1) $display("FAIL bcs_after got %b want 1", bus.br_taken); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(31) == 0); bus.en = ($urandom_range(7) != 0);
      bus.alu_a = 8'($urandom); bus.alu_b = 8'($urandom);
      bus.alu_y = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      bus.alu_carry = 1'($urandom); bus.alu_sub = 1'($urandom);
      bus.upd_nz = 1'($urandom); bus.upd_c = 1'($urandom); bus.upd_v = 1'($urandom);
      bus.bit_mode = ($urandom_range(3) == 0); bus.flag_op = 3'($urandom);
      bus.p_load = ($urandom_range(7) == 0); bus.p_in = 8'($urandom);
      bus.irq_entry = ($urandom_range(7) == 0); bus.push_brk = 1'($urandom);
      bus.br_sel = 2'($urandom); bus.br_val = 1'($urandom);
      step();
      total++; if (bus.p !== m) $display("FAIL rnd_p k=%0d got %h want %h", k, bus.p, m); else pass_cnt++;
      total++;
      if (bus.p_push !== {m[7:6], 1'b1, bus.push_brk, m[3:0]})
        $display("FAIL rnd_push k=%0d got %h want %h", k, bus.p_push, {m[7:6], 1'b1, bus.push_brk, m[3:0]});
      else pass_cnt++;
      total++; if (bus.carry_to_alu !== m[0]) $display("FAIL rnd_carry k=%0d got %b want %b", k, bus.carry_to_alu, m[0]); else pass_cnt++;
      total++;
      if (bus.br_taken !== model_br(m, bus.br_sel, bus.br_val))
        $display("FAIL rnd_br k=%0d got %b want %b", k, bus.br_taken, model_br(m, bus.br_sel, bus.br_val));
      else pass_cnt++;
    end
  endtask

  initial begin
    m = 8'h00;
    test_reset();
    test_add();
    test_sub();
    test_bit();
    test_plp_irq();
    test_branch();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
